// File: rtl/counter_job_sequencer_pkg.sv
// ----------------------------------------------------------------------------
// counter_seq_pkg
//   Shared definitions for the counter job sequencer: the sequencer state
//   encoding and the default counter / prescaler widths.
// ----------------------------------------------------------------------------
package counter_seq_pkg;

    localparam int CSQ_WIDTH = 8;   // default counter and job value width
    localparam int CSQ_DIV_W = 4;   // default prescale divider width

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        LOAD = 2'd1,
        RUN  = 2'd2,
        DONE = 2'd3
    } state_t;

endpackage

// File: rtl/counter_job_sequencer_updown_load_counter.sv
// ----------------------------------------------------------------------------
// updown_load_counter
//   Loadable up/down counter, modulo 2^WIDTH. Load has priority over Enable.
//   Ports:
//     clk      in   rising-edge clock
//     Reset    in   asynchronous active-high reset (clears Count)
//     Load     in   load Data_In on the next edge
//     Enable   in   step by one on the next edge (when not loading)
//     Up_Down  in   1 = increment, 0 = decrement
//     Data_In  in   value to load
//     Count    out  current counter value
// ----------------------------------------------------------------------------
module updown_load_counter
    import counter_seq_pkg::*;
#(
    parameter int WIDTH = CSQ_WIDTH
) (
    input  logic             clk,
    input  logic             Reset,
    input  logic             Load,
    input  logic             Enable,
    input  logic             Up_Down,
    input  logic [WIDTH-1:0] Data_In,
    output logic [WIDTH-1:0] Count
);

    logic [WIDTH-1:0] count_q;

    // Wrap in either direction is the natural modulo behaviour of the adder.
    always_ff @(posedge clk or posedge Reset) begin
        if (Reset) begin
            count_q <= '0;
        end else if (Load) begin
            count_q <= Data_In;
        end else if (Enable) begin
            count_q <= Up_Down ? count_q + 1'b1 : count_q - 1'b1;
        end
    end

    assign Count = count_q;

endmodule

// File: rtl/counter_job_sequencer.sv
// ----------------------------------------------------------------------------
// counter_job_sequencer
//   Accepts counting jobs over a valid/ready handshake and drives a shared
//   up/down counter: load the start value, step toward the end value once
//   every (div+1) unpaused RUN cycles, then pulse done. abort cancels a job
//   and pulses aborted; the counter keeps whatever value it had.
//   Ports:
//     clk, Reset                  clock, asynchronous active-high reset
//     req_valid / req_ready       job handshake (ready only in IDLE)
//     req_start, req_end          job start and terminal values
//     req_up, req_div             direction and prescale divider
//     pause                       freeze stepping while in RUN
//     abort                       cancel the active job
//     count                       counter value
//     busy                        LOAD or RUN
//     done, aborted               one-cycle completion / cancel pulses
// ----------------------------------------------------------------------------
module counter_job_sequencer
    import counter_seq_pkg::*;
#(
    parameter int WIDTH = CSQ_WIDTH,
    parameter int DIV_W = CSQ_DIV_W
) (
    input  logic             clk,
    input  logic             Reset,
    input  logic             req_valid,
    output logic             req_ready,
    input  logic [WIDTH-1:0] req_start,
    input  logic [WIDTH-1:0] req_end,
    input  logic             req_up,
    input  logic [DIV_W-1:0] req_div,
    input  logic             pause,
    input  logic             abort,
    output logic [WIDTH-1:0] count,
    output logic             busy,
    output logic             done,
    output logic             aborted
);

    state_t           state_q, state_d;
    logic [DIV_W-1:0] presc_q, presc_d;
    logic [WIDTH-1:0] start_q, start_d;
    logic [WIDTH-1:0] end_q, end_d;
    logic             up_q, up_d;
    logic [DIV_W-1:0] div_q, div_d;
    logic             done_q, done_d;
    logic             aborted_q, aborted_d;

    logic             ctr_load;
    logic             ctr_en;
    logic             at_end;

    updown_load_counter #(.WIDTH(WIDTH)) u_counter (
        .clk     (clk),
        .Reset   (Reset),
        .Load    (ctr_load),
        .Enable  (ctr_en),
        .Up_Down (up_q),
        .Data_In (start_q),
        .Count   (count)
    );

    assign at_end = (count == end_q);

    always_ff @(posedge clk or posedge Reset) begin
        if (Reset) begin
            state_q   <= IDLE;
            presc_q   <= '0;
            start_q   <= '0;
            end_q     <= '0;
            up_q      <= 1'b0;
            div_q     <= '0;
            done_q    <= 1'b0;
            aborted_q <= 1'b0;
        end else begin
            state_q   <= state_d;
            presc_q   <= presc_d;
            start_q   <= start_d;
            end_q     <= end_d;
            up_q      <= up_d;
            div_q     <= div_d;
            done_q    <= done_d;
            aborted_q <= aborted_d;
        end
    end

    // abort takes precedence over everything outside IDLE, including a
    // terminal match seen in the same cycle.
    always_comb begin
        state_d = state_q;
        unique case (state_q)
            IDLE: if (req_valid)  state_d = LOAD;
            LOAD: state_d = abort ? IDLE : RUN;
            RUN: begin
                if (abort)       state_d = IDLE;
                else if (at_end) state_d = DONE;
            end
            DONE: state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    // done/aborted are registered one cycle ahead so the pulses line up with
    // the DONE state and the IDLE cycle after an abort respectively.
    always_comb begin
        presc_d   = presc_q;
        start_d   = start_q;
        end_d     = end_q;
        up_d      = up_q;
        div_d     = div_q;
        done_d    = 1'b0;
        aborted_d = 1'b0;
        ctr_load  = 1'b0;
        ctr_en    = 1'b0;
        unique case (state_q)
            IDLE: begin
                if (req_valid) begin
                    start_d = req_start;
                    end_d   = req_end;
                    up_d    = req_up;
                    div_d   = req_div;
                end
            end
            LOAD: begin
                presc_d = '0;
                if (abort) aborted_d = 1'b1;
                else       ctr_load  = 1'b1;
            end
            RUN: begin
                if (abort) begin
                    aborted_d = 1'b1;
                end else if (at_end) begin
                    done_d = 1'b1;
                end else if (!pause) begin
                    if (presc_q == div_q) begin
                        ctr_en  = 1'b1;
                        presc_d = '0;
                    end else begin
                        presc_d = presc_q + 1'b1;
                    end
                end
            end
            DONE: begin
                if (abort) aborted_d = 1'b1;
            end
            default: ;
        endcase
    end

    assign req_ready = (state_q == IDLE);
    assign busy      = (state_q == LOAD) || (state_q == RUN);
    assign done      = done_q;
    assign aborted   = aborted_q;

endmodule
